rf_gain_write_sequencer: RTL and testbench

//  Shares the AXIRFGainBlock S00_AXI register file (4 x 32-bit gain registers at offsets 0x0/0x4/0x8/0xC) between NREQ requesters (AGC loop, SW override, calibration).

---
 rtl/rf_gain_write_sequencer_pkg.sv | 7 +
 rtl/rf_gain_write_sequencer_if.sv | 23 ++
 rtl/rf_gain_write_sequencer_arbiter.sv | 34 +++
 rtl/rf_gain_write_sequencer.sv | 107 ++++++++++
 tb/tb_rf_gain_write_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rf_gain_write_sequencer_pkg.sv
// rf_gain_seq_pkg: state encoding and AXI/register-file constants for the gain write sequencer
package rf_gain_seq_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, RESP, RDA, RDD, DONE} state_e;
  localparam int GAIN_REG_STRIDE = 4;
  localparam int NUM_GAIN_REGS = 4;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/rf_gain_write_sequencer_if.sv
// rf_gain_write_sequencer_if: AXI4-Lite bus toward the gain block (write path plus readback path)
interface rf_gain_write_sequencer_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] awaddr;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ADDR_W-1:0] araddr;
  logic arvalid, arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rf_gain_write_sequencer_arbiter.sv
// rf_gain_rr_arbiter: round-robin pick of the first request at/after the pointer; pointer advances on accept
module rf_gain_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic [NREQ-1:0] req,
  input  logic accept,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0] idx,
  output logic any
);
  logic [IW-1:0] ptr, k;
  // scan requesters starting at the pointer, first hit wins
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    k = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[k]) begin
        any = 1'b1;
        idx = k;
        grant[k] = 1'b1;
      end
    end
  end
  // winner becomes lowest priority for the next round
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) ptr <= '0;
    else if (accept) ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/rf_gain_write_sequencer.sv
// rf_gain_write_sequencer: round-robin shared AXI4-Lite writer for the RF gain registers
// Defining RFGAIN_SEQ_READBACK_EN adds a read-back verify of every write.
module rf_gain_write_sequencer
  import rf_gain_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int IW = $clog2(NREQ)
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [2*NREQ-1:0] req_idx,
  input  logic [32*NREQ-1:0] req_data,
  output logic done_valid,
  output logic [IW-1:0] done_id,
  output logic done_err,
  rf_gain_write_sequencer_if.master m_axi
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_ADDR = ADDR;
  localparam logic [2:0] S_RESP = RESP;
  localparam logic [2:0] S_DONE = DONE;
`ifdef RFGAIN_SEQ_READBACK_EN
  localparam logic [2:0] S_RDA = RDA;
  localparam logic [2:0] S_RDD = RDD;
  localparam logic [2:0] S_POST = S_RDA;
`else
  localparam logic [2:0] S_POST = S_DONE;
`endif
  logic [2:0] state, state_n;
  logic aw_v, w_v, any, accept, err;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] g;
  logic [$clog2(NUM_GAIN_REGS)-1:0] idx_q;
  logic [31:0] data_q;
  logic [ADDR_W-1:0] addr;
  rf_gain_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .ACLK(ACLK), .ARESET(ARESET), .req(req_valid), .accept(accept),
    .grant(grant), .idx(g), .any(any)
  );
  assign accept = (state == S_IDLE) && any;
  assign req_ready = accept ? grant : '0;
  assign addr = BASE_ADDR + ADDR_W'(GAIN_REG_STRIDE) * ADDR_W'(idx_q);
  assign m_axi.awaddr = aw_v ? addr : '0;
  assign m_axi.awvalid = aw_v;
  assign m_axi.wdata = data_q;
  assign m_axi.wstrb = 4'hF;
  assign m_axi.wvalid = w_v;
  assign m_axi.bready = state == S_RESP;
  assign done_valid = state == S_DONE;
  assign done_err = err;
`ifdef RFGAIN_SEQ_READBACK_EN
  assign m_axi.arvalid = state == S_RDA;
  assign m_axi.araddr = m_axi.arvalid ? addr : '0;
  assign m_axi.rready = state == S_RDD;
`else
  logic unused;
  assign unused = &{1'b0, m_axi.arready, m_axi.rvalid, m_axi.rresp, m_axi.rdata};
  assign m_axi.arvalid = 1'b0;
  assign m_axi.araddr = '0;
  assign m_axi.rready = 1'b0;
`endif
  // transaction sequencing; ADDR waits until both write channels have handshaken
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = any ? S_ADDR : S_IDLE;
      S_ADDR: state_n = (!aw_v && !w_v) ? S_RESP : S_ADDR;
      S_RESP: state_n = m_axi.bvalid ? S_POST : S_RESP;
`ifdef RFGAIN_SEQ_READBACK_EN
      S_RDA: state_n = m_axi.arready ? S_RDD : S_RDA;
      S_RDD: state_n = m_axi.rvalid ? S_DONE : S_RDD;
`endif
      default: state_n = S_IDLE;
    endcase
  end
  // latch the granted request, run independent AW/W valids, accumulate the error flag
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= S_IDLE;
      aw_v <= 1'b0;
      w_v <= 1'b0;
      idx_q <= '0;
      data_q <= '0;
      done_id <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        idx_q <= req_idx[g*2 +: 2];
        data_q <= req_data[g*32 +: 32];
        done_id <= g;
        aw_v <= 1'b1;
        w_v <= 1'b1;
      end
      if (aw_v && m_axi.awready) aw_v <= 1'b0;
      if (w_v && m_axi.wready) w_v <= 1'b0;
      if (state == S_RESP && m_axi.bvalid) err <= m_axi.bresp != AXI_RESP_OKAY;
`ifdef RFGAIN_SEQ_READBACK_EN
      if (state == S_RDD && m_axi.rvalid)
        err <= err | (m_axi.rresp != AXI_RESP_OKAY) | (m_axi.rdata != data_q);
`endif
    end
endmodule

// File: tb/tb_rf_gain_write_sequencer.sv
// tb_rf_gain_write_sequencer: scoreboard bench with an AXI4-Lite gain-block slave model
module tb_rf_gain_write_sequencer;
  localparam logic [31:0] BASE = 32'h4000_0100;
`ifdef RFGAIN_SEQ_READBACK_EN
  localparam int LAT = 6;
  localparam int SKEW_LAT = 11;
`else
  localparam int LAT = 4;
  localparam int SKEW_LAT = 9;
`endif
  typedef struct {int id; logic err; logic [31:0] addr; logic [31:0] data; int lat;} exp_t;
  logic clk = 1'b0, rst;
  logic [1:0] req_valid, req_ready;
  logic [3:0] req_idx;
  logic [63:0] req_data;
  logic done_valid, done_err;
  logic [0:0] done_id;
  rf_gain_write_sequencer_if #(.ADDR_W(32)) axi ();
  rf_gain_write_sequencer #(.NREQ(2), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .ACLK(clk), .ARESET(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_data(req_data), .done_valid(done_valid),
    .done_id(done_id), .done_err(done_err), .m_axi(axi)
  );
  initial forever #5 clk = ~clk;
  int checks = 0, passes = 0, cyc = 0, aw_hi = 0, w_hi = 0, aw_cnt = 0, aw_delay;
  logic [1:0] bresp_cfg;
  logic [31:0] rd_xor, last_addr, last_data;
  logic [31:0] mem [4];
  logic got_aw, got_w;
  logic [31:0] s_addr, s_data;
  exp_t expq[$];
  int gq[$];
  exp_t e;
  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  // slave model: ready timing, write response, memory and readback
  assign axi.awready = aw_cnt >= aw_delay;
  assign axi.wready = 1'b1;
  assign axi.arready = 1'b1;
  always @(posedge clk or posedge rst)
    if (rst) begin
      aw_cnt <= 0; got_aw <= 0; got_w <= 0; axi.bvalid <= 0; axi.bresp <= 0;
      axi.rvalid <= 0; axi.rdata <= 0; axi.rresp <= 0;
    end else begin
      if (axi.awvalid && axi.awready) begin got_aw <= 1; s_addr <= axi.awaddr; aw_cnt <= 0; end
      else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
      if (axi.wvalid && axi.wready) begin got_w <= 1; s_data <= axi.wdata; end
      if (got_aw && got_w && !axi.bvalid) begin
        axi.bvalid <= 1; axi.bresp <= bresp_cfg; got_aw <= 0; got_w <= 0;
        if (bresp_cfg == 2'b00) mem[s_addr[3:2]] <= s_data;
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 0;
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1; axi.rdata <= mem[axi.araddr[3:2]] ^ rd_xor; axi.rresp <= 0;
      end else if (axi.rvalid && axi.rready) axi.rvalid <= 0;
    end
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: record grants and write beats, check every completion against the scoreboard
  always @(negedge clk)
    if (rst) gq.delete();
    else begin
      if (req_ready != 0) gq.push_back(cyc);
      if (axi.awvalid) aw_hi++;
      if (axi.wvalid) w_hi++;
      if (axi.awvalid && axi.awready) last_addr = axi.awaddr;
      if (axi.wvalid && axi.wready) last_data = axi.wdata;
      if (done_valid) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got id %0d expected no completion", done_id);
        end else begin
          e = expq.pop_front();
          check("done_id", done_id, e.id);
          check("done_err", done_err, e.err);
          check("awaddr", last_addr, e.addr);
          check("wdata", last_data, e.data);
          check("latency", gq.size() ? cyc - gq.pop_front() : -1, e.lat);
        end
      end
    end
  task automatic push(input int r, input logic [1:0] idx, input logic [31:0] data, input logic err, input int lat);
    expq.push_back('{r, err, BASE + 32'(idx) * 4, data, lat});
  endtask
  task automatic wait_grant(input int exp_g);
    int n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 100);
    check("grant", req_ready, 2'b01 << exp_g);
    @(posedge clk); #1;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain", expq.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic issue(input int r, input logic [1:0] idx, input logic [31:0] data, input logic err, input int lat);
    req_idx[r*2 +: 2] = idx;
    req_data[r*32 +: 32] = data;
    req_valid[r] = 1'b1;
    push(r, idx, data, err, lat);
    wait_grant(r);
    req_valid[r] = 1'b0;
    wait_drain();
  endtask
  initial begin
    int a0, b0;
    rst = 1; req_valid = 0; req_idx = 0; req_data = 0;
    aw_delay = 0; bresp_cfg = 0; rd_xor = 0;
    for (int i = 0; i < 4; i++) mem[i] = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_done", {done_valid, done_id, done_err}, 0);
    check("rst_axi_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    check("rst_axi_payload", {axi.awaddr, axi.wdata}, 0);
    rst = 0;
    @(posedge clk); #1;
    check("wstrb", axi.wstrb, 4'hF);
    issue(0, 2'd2, 32'h0000_0003, 1'b0, LAT);
    check("readback_mem2", mem[2], 32'h3);
    bresp_cfg = 2'b10;
    issue(1, 2'd1, 32'hDEAD_BEEF, 1'b1, LAT);
    bresp_cfg = 2'b00;
    check("err_no_write", mem[1], 0);
    issue(1, 2'd3, 32'h1234_5678, 1'b0, LAT);
    check("readback_mem3", mem[3], 32'h1234_5678);
    req_idx = {2'd1, 2'd0};
    req_data = {32'hB000_0000, 32'hA000_0000};
    push(0, 2'd0, 32'hA000_0000, 1'b0, LAT);
    push(1, 2'd1, 32'hB000_0000, 1'b0, LAT);
    push(0, 2'd0, 32'hA000_0001, 1'b0, LAT);
    push(1, 2'd1, 32'hB000_0001, 1'b0, LAT);
    req_valid = 2'b11;
    wait_grant(0); req_data[31:0] = 32'hA000_0001;
    wait_grant(1); req_data[63:32] = 32'hB000_0001;
    wait_grant(0); req_valid[0] = 1'b0;
    wait_grant(1); req_valid[1] = 1'b0;
    wait_drain();
    aw_delay = 5;
    a0 = aw_hi; b0 = w_hi;
    issue(0, 2'd0, 32'h0000_00AA, 1'b0, SKEW_LAT);
    aw_delay = 0;
    check("skew_aw_cycles", aw_hi - a0, 6);
    check("skew_w_cycles", w_hi - b0, 1);
    req_idx[1:0] = 2'd1; req_data[31:0] = 32'h55; req_valid[0] = 1'b1;
    wait_grant(0);
    req_valid[0] = 1'b0;
    check("pre_rst_valids", {axi.awvalid, axi.wvalid}, 2'b11);
    #2 rst = 1;
    #1 check("async_rst_valids", {axi.awvalid, axi.wvalid}, 2'b00);
    repeat (3) @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk); #1;
    issue(1, 2'd0, 32'h0000_0077, 1'b0, LAT);
    check("readback_mem0", mem[0], 32'h77);
`ifdef RFGAIN_SEQ_READBACK_EN
    rd_xor = 32'h1;
    issue(0, 2'd3, 32'h0000_0F0F, 1'b1, LAT);
    rd_xor = 32'h0;
    issue(0, 2'd2, 32'h0000_1111, 1'b0, LAT);
`endif
    repeat (5) @(posedge clk);
    check("final_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
